// File: rtl/jam_cost_arbiter_if.sv
// rtl/jam_cost_arbiter_if.sv - engine request/response and cost-table port bundle
interface jam_cost_arbiter_if #(
  parameter int NREQ  = 2,
  parameter int IDXW  = 3,
  parameter int COSTW = 7
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*IDXW-1:0] req_w;
  logic [NREQ*IDXW-1:0] req_j;
  logic [NREQ-1:0]      req_last;
  logic [NREQ-1:0]      req_ready;
  logic [IDXW-1:0]      W;
  logic [IDXW-1:0]      J;
  logic [COSTW-1:0]     Cost;
  logic [NREQ-1:0]      rsp_valid;
  logic [COSTW-1:0]     rsp_cost;
  logic                 busy;

  // master = engines plus cost table; slave = the arbiter
  modport master (
    output req_valid, req_w, req_j, req_last, Cost,
    input  req_ready, W, J, rsp_valid, rsp_cost, busy
  );

  modport slave (
    input  req_valid, req_w, req_j, req_last, Cost,
    output req_ready, W, J, rsp_valid, rsp_cost, busy
  );
endinterface

// File: rtl/jam_cost_arbiter.sv
// rtl/jam_cost_arbiter.sv - round-robin cost-table port arbiter with burst lock
module jam_cost_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDXW  = 3,
  parameter int COSTW = 7
) (
  input logic              CLK,
  input logic              RST,
  jam_cost_arbiter_if.slave bus
);
  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state_q, state_d;
  logic [PTRW-1:0] owner_q, owner_d;
  logic [PTRW-1:0] ptr_q, ptr_d;

  logic [NREQ-1:0] grant;
  logic            accept;
  logic [PTRW-1:0] sel;
  logic            sel_last;
  logic            found;
  logic [PTRW-1:0] cand;

  logic [IDXW-1:0]  w_q, j_q;
  logic [PTRW-1:0]  tag_q;
  logic             iss_v_q;
  logic [NREQ-1:0]  rsp_valid_q;
  logic [COSTW-1:0] rsp_cost_q;

  // While locked only the owner can be granted; a dropped valid is just a bubble.
  always_comb begin
    grant = '0;
    sel   = '0;
    found = 1'b0;
    cand  = '0;
    if (state_q == LOCKED) begin
      sel          = owner_q;
      grant[sel]   = bus.req_valid[sel];
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        cand = PTRW'((int'(ptr_q) + k) % NREQ);
        if (!found && bus.req_valid[cand]) begin
          found       = 1'b1;
          sel         = cand;
          grant[cand] = 1'b1;
        end
      end
    end
  end

  assign accept        = |grant;
  assign sel_last      = bus.req_last[sel];
  assign bus.req_ready = grant;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (sel_last) begin
            ptr_d = sel;
          end else begin
            state_d = LOCKED;
            owner_d = sel;
          end
        end
      end
      LOCKED: begin
        if (accept && sel_last) begin
          state_d = IDLE;
          ptr_d   = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= PTRW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // Two-stage issue/return pipeline; tag follows each read so its cost goes home.
  always_ff @(posedge CLK) begin
    if (RST) begin
      w_q         <= '0;
      j_q         <= '0;
      tag_q       <= '0;
      iss_v_q     <= 1'b0;
      rsp_valid_q <= '0;
      rsp_cost_q  <= '0;
    end else begin
      iss_v_q <= accept;
      if (accept) begin
        w_q   <= bus.req_w[int'(sel)*IDXW +: IDXW];
        j_q   <= bus.req_j[int'(sel)*IDXW +: IDXW];
        tag_q <= sel;
      end
      if (iss_v_q) begin
        rsp_valid_q <= {{(NREQ-1){1'b0}}, 1'b1} << tag_q;
        rsp_cost_q  <= bus.Cost;
      end else begin
        rsp_valid_q <= '0;
      end
    end
  end

  assign bus.W         = w_q;
  assign bus.J         = j_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_cost  = rsp_cost_q;
  assign bus.busy      = (state_q == LOCKED) | iss_v_q | (|rsp_valid_q);
endmodule
